// File: rtl/dataout_buf.sv
// Output-side frame buffer: captures DEPTH result words, then streams them out with valid/ready.
// Optional registered even parity on out_data when DATAOUT_PARITY_EN is defined.
module dataout_buf #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 30,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_parity,
    output logic             done
);

    typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic             out_valid_d;
    logic             out_last_d;
    logic             done_d;
    logic [WIDTH-1:0] out_data_d;
    logic             wr_en;
    logic             hs;

    logic [WIDTH-1:0] mem [DEPTH];

    assign wr_ready = (state_q == FILL);
    assign wr_en    = wr_ready && wr_valid;
    assign hs       = out_valid && out_ready;

    // Storage is deliberately not reset; only pointers and outputs are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        done_d      = 1'b0;
        unique case (state_q)
            FILL: begin
                if (wr_en) begin
                    if (wptr_q == LAST) begin
                        wptr_d  = '0;
                        state_d = LOAD;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                out_data_d  = mem[0];
                out_valid_d = 1'b1;
                out_last_d  = (DEPTH == 1);
                rptr_d      = (DEPTH == 1) ? '0 : AW'(1);
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (hs) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rptr_d      = '0;
                        done_d      = 1'b1;
                        state_d     = FILL;
                    end else begin
                        out_data_d = mem[rptr_q];
                        out_last_d = (rptr_q == LAST);
                        rptr_d     = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= FILL;
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            done      <= done_d;
        end
    end

`ifdef DATAOUT_PARITY_EN
    // Parity tracks out_data_d, so it holds automatically whenever out_data holds.
    logic parity_q;
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^out_data_d;
        end
    end
    assign out_parity = parity_q;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_dataout_buf.sv
// Scoreboard bench for dataout_buf: accepted writes are queued, a negedge monitor checks the stream.
module tb_dataout_buf;
    localparam int WIDTH = 20;
    localparam int DEPTH = 30;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             RST;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_parity;
    logic             done;

    dataout_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .RST        (RST),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_parity (out_parity),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [WIDTH-1:0] w);
`ifdef DATAOUT_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: phase 0 = collecting, 1 = one idle cycle, 2 = streaming.
    logic [WIDTH-1:0] expq [$];
    int phase    = 0;
    int fill_cnt = 0;
    int idx      = 0;
    int hs_cnt   = 0;
    logic exp_done = 1'b0;

    always @(negedge clk) begin
        if (!RST) begin
            phase    = 0;
            fill_cnt = 0;
            idx      = 0;
            exp_done = 1'b0;
            expq.delete();
        end else begin
            chk("done", done, exp_done);
            exp_done = 1'b0;
            chk("wr_ready", wr_ready, phase == 0);
            chk("out_valid", out_valid, phase == 2);
            case (phase)
                0: if (wr_valid) begin
                    expq.push_back(wr_data);
                    fill_cnt++;
                    if (fill_cnt == DEPTH) begin
                        fill_cnt = 0;
                        phase    = 1;
                    end
                end
                1: phase = 2;
                default: begin
                    if (expq.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        chk("out_data", out_data, expq[0]);
                        chk("out_last", out_last, idx == DEPTH - 1);
                        chk("out_parity", out_parity, exp_par(expq[0]));
                        if (out_ready) begin
                            void'(expq.pop_front());
                            hs_cnt++;
                            if (idx == DEPTH - 1) begin
                                idx      = 0;
                                phase    = 0;
                                exp_done = 1'b1;
                            end else begin
                                idx++;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // out_ready pattern: 0 = always, 1 = one-on/two-off, 2 = random.
    int mode = 0;
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        rcnt++;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [WIDTH-1:0] fd [DEPTH];

    task automatic write_frame(input bit gaps);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    wr_valid = 1'b0;
                    wr_data  = WIDTH'($urandom);
                    @(posedge clk); #1;
                end
            end
            wr_valid = 1'b1;
            wr_data  = fd[i];
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input bit junk);
        int n = 0;
        forever begin
            @(posedge clk); #1;
            if (done) begin
                wr_valid = 1'b0;
                break;
            end
            if (junk) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = WIDTH'($urandom);
            end
            n++;
            if (n > 500) begin
                chk("done_timeout", 0, 1);
                wr_valid = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int target;
        RST       = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_parity", out_parity, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 1);
        RST = 1'b1;

        mode = 0;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(i);
        write_frame(0);
        wait_done(0);

        mode = 1;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(32'h00100 + i);
        write_frame(0);
        wait_done(0);

        mode = 2;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'($urandom);
        write_frame(1);
        wait_done(1);

        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(32'h50000 + i);
        write_frame(0);
        wait_done(0);
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(32'hA0000 + i);
        write_frame(0);
        wait_done(0);

        mode   = 0;
        target = hs_cnt + 11;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(32'h30000 + i);
        write_frame(0);
        for (int n = 0; n < 200 && hs_cnt < target; n++) begin
            @(posedge clk); #1;
        end
        chk("mid_drain_reached", hs_cnt >= target, 1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_wr_ready", wr_ready, 1);
        chk("async_rst_done", done, 0);
        @(posedge clk); #1;
        RST = 1'b1;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'(32'h60000 + i);
        write_frame(0);
        wait_done(0);

        mode = 2;
        for (int i = 0; i < DEPTH; i++) fd[i] = WIDTH'($urandom);
        fd[0] = 20'hFFFFE;
        fd[1] = 20'h00003;
        write_frame(1);
        wait_done(0);

        @(negedge clk); #1;
        chk("scoreboard_drained", expq.size(), 0);
        chk("model_idle", phase, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
